// File: rtl/fifo_drain_serializer.sv
// Drains 384-bit words from a first-word-fall-through FIFO and re-emits each
// as DATA_WIDTH/OUT_WIDTH narrow valid/ready beats, LSB slice first, with out_last.
module fifo_drain_serializer #(
  parameter int DATA_WIDTH = 384,
  parameter int OUT_WIDTH  = 32,
  parameter int CNT_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_r_data,
  output logic                  fifo_r_en,
  output logic [OUT_WIDTH-1:0]  out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last,
  output logic                  busy
);

  localparam int BEATS = DATA_WIDTH / OUT_WIDTH;
  localparam logic [CNT_WIDTH-1:0] LAST_BEAT = CNT_WIDTH'(BEATS - 1);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t                  state_q;
  logic [DATA_WIDTH-1:0]   shreg_q;
  logic [CNT_WIDTH-1:0]    beat_cnt_q;

  logic at_last;
  logic word_done;
  logic pop;

  // Handshake: a beat transfers on a rising edge where out_valid && out_ready;
  // once out_valid is high, out_data/out_last hold until that transfer.
  // A FIFO word is consumed on an edge where fifo_r_en is high.
  assign at_last   = (beat_cnt_q == LAST_BEAT);
  assign word_done = (state_q == SEND) && out_ready && at_last;
  assign pop       = en && !fifo_empty && ((state_q == IDLE) || word_done);
  assign fifo_r_en = pop && reset;

  assign out_valid = (state_q == SEND);
  assign busy      = (state_q == SEND);
  assign out_data  = shreg_q[OUT_WIDTH-1:0];
  assign out_last  = (state_q == SEND) && at_last;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      shreg_q    <= '0;
      beat_cnt_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pop) begin
            shreg_q    <= fifo_r_data;
            beat_cnt_q <= '0;
            state_q    <= SEND;
          end
        end
        SEND: begin
          if (out_ready) begin
            if (!at_last) begin
              shreg_q    <= shreg_q >> OUT_WIDTH;
              beat_cnt_q <= beat_cnt_q + CNT_WIDTH'(1);
            end else if (pop) begin
              // Reload on the last accepted beat keeps back-to-back words gap-free.
              shreg_q    <= fifo_r_data;
              beat_cnt_q <= '0;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_drain_serializer.sv
// Bench for fifo_drain_serializer: FIFO modelled as a queue of words, a
// reset/single-word vector table, then hand-written multi-cycle sequences.
module tb_fifo_drain_serializer;

  localparam int DW    = 384;
  localparam int OW    = 32;
  localparam int BEATS = 12;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          en = 1'b0;
  logic          fifo_empty = 1'b1;
  logic [DW-1:0] fifo_r_data = '0;
  logic          fifo_r_en;
  logic [OW-1:0] out_data;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic          out_last;
  logic          busy;

  fifo_drain_serializer #(
    .DATA_WIDTH(DW),
    .OUT_WIDTH (OW),
    .CNT_WIDTH (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .fifo_empty (fifo_empty),
    .fifo_r_data(fifo_r_data),
    .fifo_r_en  (fifo_r_en),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_last   (out_last),
    .busy       (busy)
  );

  // clock / reset block
  always #5 clk = ~clk;

  typedef struct {
    bit          rst_n;
    bit          rdy;
    bit          ren;
    bit          vld;
    logic [OW-1:0] data;
    bit          care_data;
    bit          last;
    bit          bsy;
  } vec_t;

  vec_t          vecs[18];
  int            total = 0;
  int            bad = 0;
  logic [DW-1:0] word_q[$];
  logic [OW-1:0] exp_q[$];
  bit            last_q[$];
  int            pop_idx_q[$];
  int            pops = 0;
  int            acc_beats = 0;
  int            cyc = 0;
  int            first_v = -1;
  int            last_v = -1;
  int            v_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic refresh();
    fifo_empty  = (word_q.size() == 0);
    fifo_r_data = fifo_empty ? '0 : word_q[0];
  endtask

  // One clock: the pop strobe seen just before the edge consumes the head word.
  task automatic tick();
    bit p;
    #1;
    p = fifo_r_en;
    @(posedge clk);
    cyc++;
    if (p) begin
      pops++;
      if (word_q.size() > 0) word_q.delete(0);
    end
    #1;
    refresh();
    #1;
  endtask

  task automatic push_word(input logic [OW-1:0] base, input bit to_exp);
    logic [DW-1:0] w;
    for (int k = 0; k < BEATS; k++) begin
      w[k*OW +: OW] = base + OW'(k);
      if (to_exp) begin
        exp_q.push_back(base + OW'(k));
        last_q.push_back(k == BEATS - 1);
      end
    end
    word_q.push_back(w);
    refresh();
  endtask

  task automatic clear_stats();
    pops = 0;
    acc_beats = 0;
    first_v = -1;
    last_v = -1;
    v_cnt = 0;
    pop_idx_q.delete();
  endtask

  // mode 0: out_ready always 1; mode 1: out_ready 1,0,0,1,0,0,...
  task automatic drive(input int n, input int mode);
    bit            pv = 1'b0;
    bit            pr = 1'b0;
    bit            pl = 1'b0;
    bit            hs;
    logic [OW-1:0] pd = '0;
    for (int c = 0; c < n; c++) begin
      out_ready = (mode == 0) ? 1'b1 : ((c % 3) == 0);
      #1;
      if (pv && !pr) begin
        chk("hold_valid", 64'(out_valid), 64'd1);
        chk("hold_data", 64'(out_data), 64'(pd));
        chk("hold_last", 64'(out_last), 64'(pl));
      end
      hs = out_valid && out_ready;
      if (fifo_r_en) pop_idx_q.push_back(hs ? acc_beats : -1);
      if (out_valid) begin
        v_cnt++;
        if (first_v < 0) first_v = cyc;
        last_v = cyc;
      end
      if (hs) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL extra_beat: got %0h want no beat (cycle %0d)", out_data, cyc);
        end else begin
          chk("beat_data", 64'(out_data), 64'(exp_q.pop_front()));
          chk("beat_last", 64'(out_last), 64'(last_q.pop_front()));
        end
        acc_beats++;
      end
      pv = out_valid;
      pr = out_ready;
      pd = out_data;
      pl = out_last;
      tick();
    end
  endtask

  initial begin
    // Reset held 3 cycles with a word waiting, then one word drained at full rate.
    for (int i = 0; i < 3; i++) vecs[i] = '{1'b0, 1'b1, 1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{1'b1, 1'b1, 1'b1, 1'b0, '0, 1'b1, 1'b0, 1'b0};
    for (int k = 0; k < BEATS; k++)
      vecs[4+k] = '{1'b1, 1'b1, 1'b0, 1'b1, OW'(k), 1'b1, (k == BEATS - 1), 1'b1};
    vecs[16] = '{1'b1, 1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0};
    vecs[17] = '{1'b1, 1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0};

    reset = 1'b0;
    en = 1'b1;
    push_word(32'h0, 1'b0);
    tick();
    clear_stats();

    for (int i = 0; i < 18; i++) begin
      reset = vecs[i].rst_n;
      out_ready = vecs[i].rdy;
      #1;
      chk($sformatf("v%0d_ren", i), 64'(fifo_r_en), 64'(vecs[i].ren));
      chk($sformatf("v%0d_valid", i), 64'(out_valid), 64'(vecs[i].vld));
      if (vecs[i].care_data) chk($sformatf("v%0d_data", i), 64'(out_data), 64'(vecs[i].data));
      chk($sformatf("v%0d_last", i), 64'(out_last), 64'(vecs[i].last));
      chk($sformatf("v%0d_busy", i), 64'(busy), 64'(vecs[i].bsy));
      tick();
    end
    chk("single_pops", 64'(pops), 64'd1);

    // Backpressure with ready pattern 1,0,0
    clear_stats();
    push_word(32'h100, 1'b1);
    drive(40, 1);
    chk("bp_drained", 64'(exp_q.size()), 64'd0);
    chk("bp_pops", 64'(pops), 64'd1);
    chk("bp_busy", 64'(busy), 64'd0);

    // Three words back-to-back
    clear_stats();
    push_word(32'h200, 1'b1);
    push_word(32'h300, 1'b1);
    push_word(32'h400, 1'b1);
    drive(40, 0);
    chk("b2b_drained", 64'(exp_q.size()), 64'd0);
    chk("b2b_vcnt", 64'(v_cnt), 64'd36);
    chk("b2b_span", 64'(last_v - first_v + 1), 64'd36);
    chk("b2b_npop", 64'(pop_idx_q.size()), 64'd3);
    if (pop_idx_q.size() == 3) begin
      chk("b2b_pop0", 64'(pop_idx_q[0]), 64'(-1));
      chk("b2b_pop1", 64'(pop_idx_q[1]), 64'd11);
      chk("b2b_pop2", 64'(pop_idx_q[2]), 64'd23);
    end

    // en low blocks the pop; en dropped at beat 5 lets the word finish
    clear_stats();
    en = 1'b0;
    push_word(32'h500, 1'b1);
    drive(4, 0);
    chk("en0_pops", 64'(pops), 64'd0);
    chk("en0_busy", 64'(busy), 64'd0);
    en = 1'b1;
    drive(1, 0);
    drive(5, 0);
    chk("en_beat5", 64'(out_data), 64'h505);
    push_word(32'h600, 1'b0);
    en = 1'b0;
    drive(10, 0);
    chk("en_drained", 64'(exp_q.size()), 64'd0);
    chk("en_pops", 64'(pops), 64'd1);
    chk("en_fifo_left", 64'(word_q.size()), 64'd1);
    chk("en_busy", 64'(busy), 64'd0);

    // Reset at beat 6 abandons the word; next word starts at beat 0
    clear_stats();
    for (int k = 0; k < BEATS; k++) begin
      exp_q.push_back(32'h600 + OW'(k));
      last_q.push_back(k == BEATS - 1);
    end
    en = 1'b1;
    drive(7, 0);
    chk("rst_at_beat6", 64'(out_data), 64'h606);
    push_word(32'h700, 1'b0);
    reset = 1'b0;
    #1;
    chk("rst_ren", 64'(fifo_r_en), 64'd0);
    tick();
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_data", 64'(out_data), 64'd0);
    chk("rst_last", 64'(out_last), 64'd0);
    chk("rst_word_lost", 64'(word_q.size()), 64'd1);
    exp_q.delete();
    last_q.delete();
    for (int k = 0; k < BEATS; k++) begin
      exp_q.push_back(32'h700 + OW'(k));
      last_q.push_back(k == BEATS - 1);
    end
    pops = 0;
    reset = 1'b1;
    drive(15, 0);
    chk("rst_next_drained", 64'(exp_q.size()), 64'd0);
    chk("rst_next_pops", 64'(pops), 64'd1);
    chk("rst_fifo_empty", 64'(word_q.size()), 64'd0);
    chk("rst_idle", 64'(busy), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1, "timeout");
  end

endmodule
